// File: rtl/routing_table_target.sv
// routing_table_target: programmable source-ID to return-path table with registered lookup and miss counter
// Ports: clk/rst_n; lookup lk_req/lk_src/lk_gnt -> lk_valid/lk_path/lk_miss, lk_ack;
//        programming cfg_we/cfg_addr/cfg_path/cfg_vld/cfg_clr; debug miss_cnt/miss_cnt_clr.
module routing_table_target #(
  parameter int SOURCEWD = 4,
  parameter int PATHWD = 7,
  parameter logic [(2**SOURCEWD)*PATHWD-1:0] INIT_PATHS = '0,
  parameter logic [(2**SOURCEWD)-1:0] INIT_VALID = '0,
  parameter logic [PATHWD-1:0] DEFAULT_PATH = '0,
  parameter int MISSCNTWD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lk_req,
  input  logic [SOURCEWD-1:0]  lk_src,
  output logic                 lk_gnt,
  output logic                 lk_valid,
  output logic [PATHWD-1:0]    lk_path,
  output logic                 lk_miss,
  input  logic                 lk_ack,
  input  logic                 cfg_we,
  input  logic [SOURCEWD-1:0]  cfg_addr,
  input  logic [PATHWD-1:0]    cfg_path,
  input  logic                 cfg_vld,
  input  logic                 cfg_clr,
  output logic [MISSCNTWD-1:0] miss_cnt,
  input  logic                 miss_cnt_clr
);
  localparam int NENTRIES = 2**SOURCEWD;
  logic [PATHWD-1:0] path_q [NENTRIES];
  logic [NENTRIES-1:0] valid_q;
  logic accept, hit;
  assign lk_gnt = !lk_valid || lk_ack;
  assign accept = lk_req && lk_gnt;
  assign hit = valid_q[lk_src];
  // Table reads use the pre-edge contents, so a same-cycle write is seen only by later lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENTRIES; i++) path_q[i] <= INIT_PATHS[i*PATHWD +: PATHWD];
      valid_q <= INIT_VALID;
      lk_valid <= 1'b0;
      lk_path <= '0;
      lk_miss <= 1'b0;
      miss_cnt <= '0;
    end else begin
      if (cfg_we) begin
        path_q[cfg_addr] <= cfg_path;
        valid_q[cfg_addr] <= cfg_vld;
      end
      // Later assignment wins: a clear overrides a same-cycle valid write.
      if (cfg_clr) valid_q <= '0;
      if (lk_gnt) lk_valid <= lk_req;
      if (accept) begin
        lk_path <= hit ? path_q[lk_src] : DEFAULT_PATH;
        lk_miss <= !hit;
      end
      miss_cnt <= miss_cnt_clr ? '0 : (accept && !hit && !(&miss_cnt)) ? miss_cnt + 1'b1 : miss_cnt;
    end
  end
endmodule

// File: tb/tb_routing_table_target.sv
// tb_routing_table_target: vector, directed and random checks of routing_table_target against a queue-based model
module tb_routing_table_target;
  localparam int SW = 4;
  localparam int PW = 7;
  localparam int N = 16;
  localparam int CW = 8;
  localparam logic [N*PW-1:0] IP = (112'd1 << (3*PW)) | (112'd2 << (6*PW)) | (112'd3 << (13*PW));
  localparam logic [N-1:0] IV = 16'h2049;
  localparam logic [PW-1:0] DP = 7'h7F;
  logic clk = 1'b0;
  logic rst_n, lk_req, lk_ack, cfg_we, cfg_vld, cfg_clr, miss_cnt_clr;
  logic [SW-1:0] lk_src, cfg_addr;
  logic [PW-1:0] cfg_path;
  logic lk_gnt, lk_valid, lk_miss;
  logic [PW-1:0] lk_path;
  logic [CW-1:0] miss_cnt;
  always #5 clk = ~clk;
  routing_table_target #(.SOURCEWD(SW), .PATHWD(PW), .INIT_PATHS(IP), .INIT_VALID(IV),
    .DEFAULT_PATH(DP), .MISSCNTWD(CW)) dut (
    .clk(clk), .rst_n(rst_n), .lk_req(lk_req), .lk_src(lk_src), .lk_gnt(lk_gnt),
    .lk_valid(lk_valid), .lk_path(lk_path), .lk_miss(lk_miss), .lk_ack(lk_ack),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_path(cfg_path), .cfg_vld(cfg_vld),
    .cfg_clr(cfg_clr), .miss_cnt(miss_cnt), .miss_cnt_clr(miss_cnt_clr));
  typedef struct { logic [PW-1:0] p; bit m; } res_t;
  typedef struct { logic [SW-1:0] src; logic [PW-1:0] p; bit m; } vec_t;
  int errs = 0;
  int checks = 0;
  logic [PW-1:0] m_path [N];
  bit m_valid [N];
  res_t held_q [$];
  res_t m_last;
  int m_cnt;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_path[i] = IP[i*PW +: PW];
      m_valid[i] = IV[i];
    end
    held_q.delete();
    m_last = '{p: '0, m: 1'b0};
    m_cnt = 0;
  endfunction
  task automatic check_outs();
    chk("valid", lk_valid, held_q.size() != 0);
    chk("path", lk_path, m_last.p);
    chk("miss", lk_miss, m_last.m);
    chk("miss_cnt", miss_cnt, m_cnt);
  endtask
  task automatic tick();
    bit acc;
    res_t r;
    #1;
    acc = lk_req && (held_q.size() == 0 || lk_ack);
    chk("gnt", lk_gnt, held_q.size() == 0 || lk_ack);
    r.p = m_valid[lk_src] ? m_path[lk_src] : DP;
    r.m = !m_valid[lk_src];
    @(posedge clk);
    if (held_q.size() != 0 && lk_ack) void'(held_q.pop_front());
    if (acc) begin
      held_q.push_back(r);
      m_last = r;
      if (r.m && m_cnt < 255) m_cnt++;
    end
    if (miss_cnt_clr) m_cnt = 0;
    if (cfg_we) begin
      m_path[cfg_addr] = cfg_path;
      m_valid[cfg_addr] = cfg_vld;
    end
    if (cfg_clr) foreach (m_valid[i]) m_valid[i] = 1'b0;
    #1;
    check_outs();
  endtask
  vec_t vecs [5];
  initial begin
    vecs = '{'{4'h0, 7'h00, 1'b0}, '{4'h3, 7'h01, 1'b0}, '{4'h6, 7'h02, 1'b0},
             '{4'hd, 7'h03, 1'b0}, '{4'h5, 7'h7F, 1'b1}};
    rst_n = 1'b0; lk_req = 0; lk_src = 0; lk_ack = 0; cfg_we = 0; cfg_addr = 0;
    cfg_path = 0; cfg_vld = 0; cfg_clr = 0; miss_cnt_clr = 0;
    m_reset();
    #2;
    chk("rst_gnt", lk_gnt, 1);
    check_outs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // reset contents, back-to-back with ack high
    lk_ack = 1;
    for (int i = 0; i < 5; i++) begin
      lk_req = 1; lk_src = vecs[i].src;
      tick();
      chk("vec_valid", lk_valid, 1);
      chk("vec_path", lk_path, vecs[i].p);
      chk("vec_miss", lk_miss, vecs[i].m);
    end
    lk_req = 0;
    tick();
    chk("vec_cnt", miss_cnt, 1);
    // back-pressure
    lk_req = 1; lk_src = 4'h6;
    tick();
    lk_src = 4'h3; lk_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_gnt", lk_gnt, 0);
      tick();
      chk("bp_path", lk_path, 2);
    end
    lk_ack = 1;
    tick();
    chk("bp_release", lk_path, 1);
    lk_req = 0;
    tick();
    // programming collision
    lk_req = 1; lk_src = 4'h3; cfg_we = 1; cfg_addr = 4'h3; cfg_path = 7'h55; cfg_vld = 1;
    tick();
    chk("col_old", lk_path, 1);
    cfg_we = 0;
    tick();
    chk("col_new", lk_path, 7'h55);
    lk_req = 0;
    tick();
    // invalidate and clear priority
    cfg_we = 1; cfg_addr = 4'h6; cfg_path = 7'h22; cfg_vld = 0;
    tick();
    cfg_we = 0; lk_req = 1; lk_src = 4'h6;
    tick();
    chk("inv_path", lk_path, 7'h7F);
    chk("inv_miss", lk_miss, 1);
    lk_req = 0; cfg_clr = 1; cfg_we = 1; cfg_addr = 4'h0; cfg_path = 7'h11; cfg_vld = 1;
    tick();
    cfg_clr = 0; cfg_we = 0; lk_req = 1; lk_src = 4'h0;
    tick();
    chk("clr_path", lk_path, 7'h7F);
    chk("clr_miss", lk_miss, 1);
    // saturation and clear
    lk_src = 4'h5;
    for (int i = 0; i < 260; i++) tick();
    chk("sat_cnt", miss_cnt, 8'hFF);
    miss_cnt_clr = 1;
    tick();
    chk("clr_cnt", miss_cnt, 0);
    miss_cnt_clr = 0; lk_req = 0;
    tick();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      lk_req = $urandom_range(0, 3) != 0;
      lk_src = SW'($urandom);
      lk_ack = $urandom_range(0, 2) != 0;
      cfg_we = $urandom_range(0, 5) == 0;
      cfg_addr = SW'($urandom);
      cfg_path = PW'($urandom);
      cfg_vld = $urandom_range(0, 3) != 0;
      cfg_clr = $urandom_range(0, 40) == 0;
      miss_cnt_clr = $urandom_range(0, 60) == 0;
      tick();
    end
    lk_req = 0; cfg_we = 0; cfg_clr = 0; miss_cnt_clr = 0; lk_ack = 1;
    tick();
    // asynchronous reset with a held result
    lk_req = 1; lk_src = 4'h6; lk_ack = 0;
    tick();
    lk_req = 0;
    tick();
    chk("ar_held", lk_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("ar_gnt", lk_gnt, 1);
    check_outs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_outs();
    lk_req = 1; lk_src = 4'h3; lk_ack = 1;
    tick();
    chk("ar_init", lk_path, 1);
    lk_req = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
